// File: rtl/io_load_pkg.sv
// Shared types and opcode field layout for the IO load unit.
// Also holds the size encodings used by the load path and the alignment helper.
package io_load_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQUEST   = 2'd1,
        ST_WAIT      = 2'd2,
        ST_WRITEBACK = 2'd3
    } load_state_t;

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_WORD   = 2'b01;
    localparam logic [1:0] SIZE_DOUBLE = 2'b10;
    localparam logic [1:0] SIZE_QUAD   = 2'b11;

    localparam int SIZE_LSB    = 0;
    localparam int SIZE_WIDTH  = 2;
    localparam int SIGNEXT_BIT = 2;

    // Access size in bits for a size encoding: 8, 16, 32 or 64.
    function automatic int sizeBits(input logic [1:0] size);
        return 8 << size;
    endfunction

endpackage

// File: rtl/io_load_if.sv
// Bundle of load request, IO bus and writeback handshakes for the IO load unit.
// The slave modport is the load unit; the master modport is its surroundings.
interface io_load_if
    import io_load_pkg::*;
#(
    parameter int DATABITWIDTH = 16
);

    logic                    LoadValid;
    logic                    LoadReady;
    logic [3:0]              MinorOpcodeIn;
    logic [DATABITWIDTH-1:0] DataAddrIn;
    logic [3:0]              DestRegIn;

    logic                    IOReqValid;
    logic                    IOReqReady;
    logic [DATABITWIDTH-1:0] IOReqAddr;
    logic                    IORespValid;
    logic [DATABITWIDTH-1:0] IORespData;

    logic                    WBValid;
    logic                    WBReady;
    logic [DATABITWIDTH-1:0] WBData;
    logic [3:0]              WBDest;
    logic                    WBError;

    modport slave (
        input  LoadValid, MinorOpcodeIn, DataAddrIn, DestRegIn,
        input  IOReqReady, IORespValid, IORespData, WBReady,
        output LoadReady, IOReqValid, IOReqAddr,
        output WBValid, WBData, WBDest, WBError
    );

    modport master (
        output LoadValid, MinorOpcodeIn, DataAddrIn, DestRegIn,
        output IOReqReady, IORespValid, IORespData, WBReady,
        input  LoadReady, IOReqValid, IOReqAddr,
        input  WBValid, WBData, WBDest, WBError
    );

endinterface

// File: rtl/io_load_align.sv
// Combinational extract-and-extend of a naturally aligned field from a full IO data word.
// Sizes wider than the data path yield all ones.
module io_load_align
    import io_load_pkg::*;
#(
    parameter int DATABITWIDTH = 16
) (
    input  logic [DATABITWIDTH-1:0] i_data,
    input  logic [DATABITWIDTH-1:0] i_addr,
    input  logic [1:0]              i_size,
    input  logic                    i_signExt,
    output logic [DATABITWIDTH-1:0] o_data
);

    localparam logic [DATABITWIDTH-1:0] LANEMASK = DATABITWIDTH'(DATABITWIDTH / 8 - 1);
    localparam logic [DATABITWIDTH-1:0] ONE      = DATABITWIDTH'(1);

    int                      w_fieldBits;
    int                      w_lane;
    int                      w_shift;
    logic [DATABITWIDTH-1:0] w_shifted;
    logic [DATABITWIDTH-1:0] w_mask;
    logic                    w_msb;

    // Lane bits below the access size are dropped so the field start stays naturally aligned.
    always_comb begin
        w_fieldBits = sizeBits(i_size);
        w_lane      = int'(i_addr & LANEMASK);
        w_shift     = ((w_lane >> i_size) << i_size) * 8;
        w_shifted   = i_data >> w_shift;
        w_mask      = (w_fieldBits >= DATABITWIDTH) ? '1 : ((ONE << w_fieldBits) - ONE);
        w_msb       = |(w_shifted & (w_mask ^ (w_mask >> 1)));
        if (w_fieldBits > DATABITWIDTH) begin
            o_data = '1;
        end else begin
            o_data = (w_shifted & w_mask) | ((i_signExt && w_msb) ? ~w_mask : '0);
        end
    end

endmodule

// File: rtl/io_load_unit.sv
// Single-outstanding IO load unit: accept a load, issue an aligned IO read, wait with a
// timeout, then hold an aligned and extended result until the writeback sink takes it.
module io_load_unit
    import io_load_pkg::*;
#(
    parameter int DATABITWIDTH  = 16,
    parameter int TIMEOUTCYCLES = 64
) (
    input  logic     clk,
    input  logic     async_rst_n,
    io_load_if.slave bus
);

    localparam int                      CNTBITS  = $clog2(TIMEOUTCYCLES + 1);
    localparam logic [CNTBITS-1:0]      CNTLAST  = CNTBITS'(TIMEOUTCYCLES - 1);
    localparam logic [DATABITWIDTH-1:0] LANEMASK = DATABITWIDTH'(DATABITWIDTH / 8 - 1);

    load_state_t             r_state;
    logic [1:0]              r_size;
    logic                    r_signExt;
    logic [DATABITWIDTH-1:0] r_addr;
    logic [3:0]              r_dest;
    logic [CNTBITS-1:0]      r_count;
    logic                    r_loadReady;
    logic                    r_ioReqValid;
    logic                    r_wbValid;
    logic [DATABITWIDTH-1:0] r_wbData;
    logic [3:0]              r_wbDest;
    logic                    r_wbError;
    logic [DATABITWIDTH-1:0] w_alignData;

    io_load_align #(
        .DATABITWIDTH (DATABITWIDTH)
    ) u_align (
        .i_data    (bus.IORespData),
        .i_addr    (r_addr),
        .i_size    (r_size),
        .i_signExt (r_signExt),
        .o_data    (w_alignData)
    );

    // Outputs are all registered; LoadReady rises on the first clock after reset release.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_state      <= ST_IDLE;
            r_size       <= '0;
            r_signExt    <= 1'b0;
            r_addr       <= '0;
            r_dest       <= '0;
            r_count      <= '0;
            r_loadReady  <= 1'b0;
            r_ioReqValid <= 1'b0;
            r_wbValid    <= 1'b0;
            r_wbData     <= '0;
            r_wbDest     <= '0;
            r_wbError    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_loadReady <= 1'b1;
                    if (bus.LoadValid && r_loadReady) begin
                        r_size       <= bus.MinorOpcodeIn[SIZE_LSB +: SIZE_WIDTH];
                        r_signExt    <= bus.MinorOpcodeIn[SIGNEXT_BIT];
                        r_addr       <= bus.DataAddrIn;
                        r_dest       <= bus.DestRegIn;
                        r_loadReady  <= 1'b0;
                        r_ioReqValid <= 1'b1;
                        r_state      <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if (bus.IOReqReady) begin
                        r_ioReqValid <= 1'b0;
                        r_count      <= '0;
                        r_state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response arriving on the timeout cycle still wins.
                    if (bus.IORespValid) begin
                        r_wbData  <= w_alignData;
                        r_wbError <= 1'b0;
                        r_wbDest  <= r_dest;
                        r_wbValid <= 1'b1;
                        r_state   <= ST_WRITEBACK;
                    end else if (r_count == CNTLAST) begin
                        r_wbData  <= '1;
                        r_wbError <= 1'b1;
                        r_wbDest  <= r_dest;
                        r_wbValid <= 1'b1;
                        r_state   <= ST_WRITEBACK;
                    end else begin
                        r_count <= r_count + CNTBITS'(1);
                    end
                end
                ST_WRITEBACK: begin
                    if (bus.WBReady) begin
                        r_wbValid   <= 1'b0;
                        r_loadReady <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.LoadReady  = r_loadReady;
    assign bus.IOReqValid = r_ioReqValid;
    assign bus.IOReqAddr  = r_addr & ~LANEMASK;
    assign bus.WBValid    = r_wbValid;
    assign bus.WBData     = r_wbData;
    assign bus.WBDest     = r_wbDest;
    assign bus.WBError    = r_wbError;

endmodule

// File: tb/tb_io_load_unit.sv
// Randomized bench for io_load_unit at 32-bit width with a 64-cycle timeout,
// compared against an arithmetic model of the load result and handshake timing.
module tb_io_load_unit;
    import io_load_pkg::*;

    localparam int W  = 32;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rstN;
    int   vectorCount = 0;
    int   missCount   = 0;

    always #5 clk = ~clk;

    io_load_if #(.DATABITWIDTH(W)) bus ();

    io_load_unit #(
        .DATABITWIDTH  (W),
        .TIMEOUTCYCLES (TO)
    ) dut (
        .clk         (clk),
        .async_rst_n (rstN),
        .bus         (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Expected load result from plain arithmetic on byte offsets and field spans.
    function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [3:0] op, input logic [31:0] resp);
        int bytes;
        int off;
        longint unsigned span;
        longint unsigned field;
        bytes = 1 << op[1:0];
        if (bytes > W / 8) return 32'hFFFF_FFFF;
        off   = ((int'(addr % 4)) / bytes) * bytes;
        span  = 64'd1 << (8 * bytes);
        field = ({32'd0, resp} >> (8 * off)) % span;
        if (op[2] && field >= span / 2) field = field + 64'h1_0000_0000 - span;
        return field[31:0];
    endfunction

    // One full load: accept, request with optional stall, wait/timeout, writeback with backpressure.
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] op, input logic [3:0] dest,
                                 input logic [31:0] resp, input int reqDelay, input int respAt, input int stall);
        logic [31:0] expData;
        logic        expErr;
        int          expCyc;
        int          cyc;
        if (respAt < TO) begin
            expData = modelLoad(addr, op, resp);
            expErr  = 1'b0;
            expCyc  = respAt + 1;
        end else begin
            expData = 32'hFFFF_FFFF;
            expErr  = 1'b1;
            expCyc  = TO;
        end
        checkOutput("loadReadyIdle", bus.LoadReady, 1);
        bus.LoadValid     = 1'b1;
        bus.MinorOpcodeIn = op;
        bus.DataAddrIn    = addr;
        bus.DestRegIn     = dest;
        @(posedge clk); #1;
        bus.LoadValid  = 1'b0;
        bus.DataAddrIn = $urandom;
        bus.DestRegIn  = 4'($urandom);
        checkOutput("ioReqValid", bus.IOReqValid, 1);
        checkOutput("ioReqAddr", bus.IOReqAddr, addr & 32'hFFFF_FFFC);
        checkOutput("loadReadyBusy", bus.LoadReady, 0);
        for (int i = 0; i < reqDelay; i++) begin
            bus.IORespValid = 1'b1;
            bus.IORespData  = $urandom;
            bus.LoadValid   = 1'b1;
            @(posedge clk); #1;
            checkOutput("ioReqHold", bus.IOReqValid, 1);
            checkOutput("ioReqAddrHold", bus.IOReqAddr, addr & 32'hFFFF_FFFC);
            checkOutput("noWbInRequest", bus.WBValid, 0);
        end
        bus.LoadValid   = 1'b0;
        bus.IORespValid = 1'b0;
        bus.IOReqReady  = 1'b1;
        @(posedge clk); #1;
        bus.IOReqReady = 1'b0;
        checkOutput("ioReqDrop", bus.IOReqValid, 0);
        cyc = 0;
        while (bus.WBValid !== 1'b1 && cyc < 200) begin
            if (cyc == respAt) begin
                bus.IORespValid = 1'b1;
                bus.IORespData  = resp;
            end else begin
                bus.IORespValid = 1'b0;
                bus.IORespData  = $urandom;
            end
            @(posedge clk); #1;
            bus.IORespValid = 1'b0;
            cyc++;
        end
        checkOutput("waitCycles", cyc, expCyc);
        checkOutput("wbValid", bus.WBValid, 1);
        checkOutput("wbData", bus.WBData, expData);
        checkOutput("wbDest", bus.WBDest, dest);
        checkOutput("wbError", bus.WBError, expErr);
        for (int i = 0; i < stall; i++) begin
            bus.IORespValid = (i == 0) ? 1'b1 : 1'($urandom);
            bus.IORespData  = $urandom;
            bus.LoadValid   = 1'($urandom);
            @(posedge clk); #1;
            checkOutput("wbValidStall", bus.WBValid, 1);
            checkOutput("wbDataStall", bus.WBData, expData);
            checkOutput("wbDestStall", bus.WBDest, dest);
            checkOutput("wbErrorStall", bus.WBError, expErr);
            checkOutput("loadReadyStall", bus.LoadReady, 0);
        end
        bus.IORespValid = 1'b0;
        bus.LoadValid   = 1'b0;
        bus.WBReady     = 1'b1;
        @(posedge clk); #1;
        bus.WBReady = 1'b0;
        checkOutput("wbValidDone", bus.WBValid, 0);
        checkOutput("loadReadyDone", bus.LoadReady, 1);
    endtask

    initial begin
        int respAt;
        int pick;
        bus.LoadValid     = 1'b0;
        bus.MinorOpcodeIn = '0;
        bus.DataAddrIn    = '0;
        bus.DestRegIn     = '0;
        bus.IOReqReady    = 1'b0;
        bus.IORespValid   = 1'b0;
        bus.IORespData    = '0;
        bus.WBReady       = 1'b0;
        rstN = 1'b1;
        #1 rstN = 1'b0;
        #2;
        checkOutput("rstLoadReady", bus.LoadReady, 0);
        checkOutput("rstIoReqValid", bus.IOReqValid, 0);
        checkOutput("rstIoReqAddr", bus.IOReqAddr, 0);
        checkOutput("rstWbValid", bus.WBValid, 0);
        checkOutput("rstWbData", bus.WBData, 0);
        checkOutput("rstWbError", bus.WBError, 0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
        checkOutput("loadReadyAfterReset", bus.LoadReady, 1);

        applyStimulus(32'h0000_0003, {2'b01, SIZE_BYTE}, 4'h5, 32'h80FF_1234, 0, 0, 0);
        applyStimulus(32'h0000_0002, {2'b00, SIZE_WORD}, 4'hA, 32'hBEEF_1234, 1, 2, 1);
        applyStimulus(32'h0000_0001, {2'b01, SIZE_QUAD}, 4'h3, 32'h1234_5678, 0, 1, 0);
        applyStimulus(32'h0000_0040, {2'b01, SIZE_DOUBLE}, 4'h7, 32'h0000_0000, 0, TO, 2);
        applyStimulus(32'h0000_0005, {2'b01, SIZE_BYTE}, 4'h9, 32'h0000_F100, 0, TO - 1, 0);
        applyStimulus(32'h1234_5676, {2'b11, SIZE_WORD}, 4'hC, 32'h8001_7FFF, 2, 3, 5);

        for (int n = 0; n < 30; n++) begin
            pick = $urandom_range(0, 9);
            if (pick < 7)       respAt = $urandom_range(0, 4);
            else if (pick == 7) respAt = TO - 1;
            else                respAt = TO;
            applyStimulus($urandom, 4'($urandom), 4'($urandom), $urandom,
                          $urandom_range(0, 2), respAt, $urandom_range(0, 3));
        end

        // Reset while waiting for a response abandons the load.
        checkOutput("loadReadyPreReset", bus.LoadReady, 1);
        bus.LoadValid     = 1'b1;
        bus.MinorOpcodeIn = 4'b0100;
        bus.DataAddrIn    = 32'hDEAD_BEEF;
        bus.DestRegIn     = 4'h9;
        @(posedge clk); #1;
        bus.LoadValid  = 1'b0;
        bus.IOReqReady = 1'b1;
        @(posedge clk); #1;
        bus.IOReqReady = 1'b0;
        repeat (3) @(posedge clk);
        #3 rstN = 1'b0;
        #1;
        checkOutput("waitRstLoadReady", bus.LoadReady, 0);
        checkOutput("waitRstIoReqValid", bus.IOReqValid, 0);
        checkOutput("waitRstIoReqAddr", bus.IOReqAddr, 0);
        checkOutput("waitRstWbValid", bus.WBValid, 0);
        checkOutput("waitRstWbData", bus.WBData, 0);
        checkOutput("waitRstWbDest", bus.WBDest, 0);
        checkOutput("waitRstWbError", bus.WBError, 0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
        checkOutput("loadReadyAfterWaitRst", bus.LoadReady, 1);
        for (int i = 0; i < 3; i++) begin
            bus.IORespValid = 1'b1;
            bus.IORespData  = $urandom;
            @(posedge clk); #1;
            checkOutput("lateRespNoWb", bus.WBValid, 0);
            checkOutput("lateRespIdle", bus.LoadReady, 1);
        end
        bus.IORespValid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
